muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 flush  input  1  synchronous abort of any in-flight operation (pipeline kill).
REQ-006 op  input  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 rs1  input  32  first operand.
REQ-008 rs2  input  32  second operand.
REQ-009 busy  output  1  high while an operation is in flight (any state other than IDLE).
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  32  registered result; holds its value until the next done or reset.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and FIX, with transitions IDLE->CALC on accept, CALC->FIX after 32 iterations, and FIX->IDLE with done.
REQ-013 Accept occurs when start=1, flush=0 and state=IDLE at edge N; op, rs1 and rs2 are latched at N, and later input changes SHALL be ignored.
REQ-014 Signedness at latch: mul/mulh/div/rem use both operands signed; mulhsu uses signed rs1 and unsigned rs2; mulhu/divu/remu use both unsigned. Magnitudes (two's-complement negation of negative signed operands) are latched, along with the operand signs.
REQ-015 Multiply SHALL be a 32-step shift-add on the magnitudes into a 64-bit product, one step per edge from N+1 to N+32.
REQ-016 Divide/remainder SHALL be a 32-step restoring division on the magnitudes, yielding a 32-bit quotient and a 32-bit remainder, one step per edge from N+1 to N+32.
REQ-017 The iteration counter SHALL be 5 bits; the CALC->FIX transition occurs on the 32nd step, when the counter wraps from 31.
REQ-018 In FIX, the product is negated if the signs differ (for ops with signed operands); the quotient is negated if sign(rs1)^sign(rs2); the remainder takes the sign of rs1.
REQ-019 Result selection: mul = product[31:0]; mulh/mulhsu/mulhu = product[63:32]; div/divu = quotient; rem/remu = remainder.
REQ-020 At edge N+33, result SHALL be registered, done=1 for exactly one cycle, and state becomes IDLE; busy=1 for cycles N+1 through N+33, i.e. until the edge at which done rises, after which busy=0.
REQ-021 Divide-by-zero (rs2=0, ops 1xx) SHALL bypass CALC: at N+1 done=1 with div/divu result 0xFFFFFFFF and rem/remu result rs1.
REQ-022 Signed overflow (div/rem, rs1=0x80000000, rs2=0xFFFFFFFF) SHALL bypass CALC: at N+1 done=1 with div result 0x80000000 and rem result 0.
REQ-023 start while busy=1 SHALL be ignored, with no queueing.
REQ-024 Back-to-back: start in the same cycle that done=1 SHALL be accepted, because state is IDLE in that cycle.
REQ-025 flush=1 in CALC or FIX SHALL move the FSM to IDLE at the next edge, with no done pulse and result unchanged; flush=1 with start=1 in IDLE SHALL cause start to be ignored.
REQ-026 done SHALL never be asserted while busy=1 in the same cycle, except for the single done cycle, in which busy=0.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, counter=0, busy=0, done=0, result=0x00000000, and all internal operand/accumulator registers cleared.
REQ-028 rst asserted mid-operation SHALL abort it with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-029 mul, rs1=7, rs2=0xFFFFFFFD (-3), start at edge N -> busy from N+1, done at N+33, result=0xFFFFFFEB; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; mulh 0x80000000*0x80000000 -> 0x40000000; mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 div 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD at N+33; rem of the same operands -> 0xFFFFFFFF; divu 100/7 -> 14; remu 100/7 -> 2.
REQ-031 divu 5/0 -> 0xFFFFFFFF with done at N+1; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000 with done at N+1; rem of the same operands -> 0.
REQ-032 start pulsed again at N+5 with different operands -> ignored, and the result matches the first operation; start held high continuously -> a new accept on each done cycle, with done every 34 edges.
REQ-033 flush at N+10 -> no done pulse, busy=0 after N+11, result holds its prior value; a following start completes normally.
REQ-034 rst asserted between clock edges during CALC -> busy, done and result go to 0 immediately without waiting for clk; the next operation after release is correct.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle for the RV32M multiply/divide sequencer.
// The master issues operations; the slave (the sequencer) reports busy/done/result.
interface muldiv_sequencer_if;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, flush, op, rs1, rs2, input busy, done, result);
  modport slave  (input start, flush, op, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring
// divide on operand magnitudes, followed by a sign fix-up cycle.
module muldiv_sequencer (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  state_t      state_r, state_next_s;
  logic [2:0]  op_r;
  logic        sign1_r, sign2_r, dz_r, ovf_r, done_r;
  logic [31:0] b_r, acc_hi_r, acc_lo_r, result_r;
  logic [4:0]  cnt_r;

  logic        accept_s, done_next_s;
  logic        rs1_signed_s, rs2_signed_s, sign1_in_s, sign2_in_s, dz_in_s, ovf_in_s;
  logic [31:0] mag1_s, mag2_s, step_hi_s, step_lo_s, fix_result_s;
  logic [32:0] sum_s, rem_shift_s, diff_s;
  logic [63:0] prod_s;

  // Operand decode at the accept edge: signedness, magnitudes and bypass cases.
  always_comb begin
    accept_s     = (state_r == IDLE) && bus.start && !bus.flush;
    rs1_signed_s = bus.op[2] ? !bus.op[0] : (bus.op[1:0] != 2'b11);
    rs2_signed_s = bus.op[2] ? !bus.op[0] : !bus.op[1];
    sign1_in_s   = rs1_signed_s && bus.rs1[31];
    sign2_in_s   = rs2_signed_s && bus.rs2[31];
    mag1_s       = cneg32(bus.rs1, sign1_in_s);
    mag2_s       = cneg32(bus.rs2, sign2_in_s);
    dz_in_s      = bus.op[2] && (bus.rs2 == 32'd0);
    ovf_in_s     = bus.op[2] && !bus.op[0] && (bus.rs1 == 32'h8000_0000) &&
                   (bus.rs2 == 32'hFFFF_FFFF);
  end

  // One iteration: acc_lo holds the multiplier (mul) or the dividend bits still to shift in (div).
  always_comb begin
    step_hi_s   = acc_hi_r;
    step_lo_s   = acc_lo_r;
    sum_s       = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, b_r} : 33'd0);
    rem_shift_s = {acc_hi_r, acc_lo_r[31]};
    diff_s      = rem_shift_s - {1'b0, b_r};
    if (op_r[2]) begin
      if (diff_s[32]) begin
        step_hi_s = rem_shift_s[31:0];
        step_lo_s = {acc_lo_r[30:0], 1'b0};
      end else begin
        step_hi_s = diff_s[31:0];
        step_lo_s = {acc_lo_r[30:0], 1'b1};
      end
    end else begin
      step_hi_s = sum_s[32:1];
      step_lo_s = {sum_s[0], acc_lo_r[31:1]};
    end
  end

  // Sign fix-up and result selection; bypassed divides never iterate, so acc_lo still holds |rs1|.
  always_comb begin
    prod_s       = cneg64({acc_hi_r, acc_lo_r}, sign1_r ^ sign2_r);
    fix_result_s = 32'd0;
    case (op_r)
      3'b000: fix_result_s = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fix_result_s = prod_s[63:32];
      3'b100, 3'b101: begin
        if (dz_r) begin
          fix_result_s = 32'hFFFF_FFFF;
        end else if (ovf_r) begin
          fix_result_s = 32'h8000_0000;
        end else begin
          fix_result_s = cneg32(acc_lo_r, sign1_r ^ sign2_r);
        end
      end
      3'b110, 3'b111: begin
        if (dz_r) begin
          fix_result_s = cneg32(acc_lo_r, sign1_r);
        end else if (ovf_r) begin
          fix_result_s = 32'd0;
        end else begin
          fix_result_s = cneg32(acc_hi_r, sign1_r);
        end
      end
      default: fix_result_s = 32'd0;
    endcase
  end

  // Next-state logic; flush kills any in-flight operation without a done pulse.
  always_comb begin
    state_next_s = state_r;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = (dz_in_s || ovf_in_s) ? FIX : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_next_s = IDLE;
        end else if (cnt_r == 5'd31) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX: begin
        state_next_s = IDLE;
        done_next_s  = !bus.flush;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 3'd0;
      sign1_r  <= 1'b0;
      sign2_r  <= 1'b0;
      dz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      b_r      <= 32'd0;
      acc_hi_r <= 32'd0;
      acc_lo_r <= 32'd0;
      cnt_r    <= 5'd0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
    end else begin
      done_r <= done_next_s;
      if (accept_s) begin
        op_r     <= bus.op;
        sign1_r  <= sign1_in_s;
        sign2_r  <= sign2_in_s;
        dz_r     <= dz_in_s;
        ovf_r    <= ovf_in_s;
        b_r      <= mag2_s;
        acc_hi_r <= 32'd0;
        acc_lo_r <= mag1_s;
        cnt_r    <= 5'd0;
      end else if (state_r == CALC) begin
        acc_hi_r <= step_hi_s;
        acc_lo_r <= step_lo_s;
        cnt_r    <= cnt_r + 5'd1;
      end
      if (done_next_s) begin
        result_r <= fix_result_s;
      end
    end
  end

  assign bus.busy   = (state_r != IDLE);
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a 64-bit arithmetic reference.
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();
  muldiv_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_exp = 32'd0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 32'd0)) return 1;
    if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation, scramble inputs after accept, and check latency/result/pulse width.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic [31:0] exp;
    int          lat;
    exp = ref_model(op, a, b);
    bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'($urandom); bus.rs1 = $urandom; bus.rs2 = $urandom;
    check_value({tag, " busy"}, 32'(bus.busy), 32'd1);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      if (inject && k == 5) bus.start = 1'b1;
      if (inject && k == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    check_value({tag, " latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
    check_value({tag, " result"}, bus.result, exp);
    check_value({tag, " busy@done"}, 32'(bus.busy), 32'd0);
    last_exp = exp;
    @(posedge clk); #1;
    check_value({tag, " done pulse"}, 32'(bus.done), 32'd0);
    check_value({tag, " hold"}, bus.result, exp);
  endtask

  logic [2:0]  dir_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] dir_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, exp1, exp2;
    int          lat, seen;

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.rs1 = 32'd0; bus.rs2 = 32'd0;
    #12;
    check_value("reset busy", 32'(bus.busy), 32'd0);
    check_value("reset done", 32'(bus.done), 32'd0);
    check_value("reset result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_op($sformatf("dir%0d", i), dir_op[i], dir_a[i], dir_b[i], 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, 1'b0);
    end

    run_op("inject", 3'd4, 32'hFFFF_0123, 32'd37, 1'b1);

    // Start held high: second operation accepted in the first done cycle.
    exp1 = ref_model(3'd5, 32'd1000, 32'd9);
    exp2 = ref_model(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    bus.op = 3'd5; bus.rs1 = 32'd1000; bus.rs2 = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.op = 3'd0; bus.rs1 = 32'h1234_5678; bus.rs2 = 32'h9ABC_DEF0;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    check_value("b2b first latency", 32'(lat), 32'd33);
    check_value("b2b first result", bus.result, exp1);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    bus.start = 1'b0;
    check_value("b2b second spacing", 32'(lat), 32'd34);
    check_value("b2b second result", bus.result, exp2);
    @(posedge clk); #1;
    check_value("b2b stop", 32'(bus.busy), 32'd0);
    last_exp = exp2;

    // Flush at N+10.
    bus.op = 3'd1; bus.rs1 = $urandom; bus.rs2 = $urandom; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_value("flush busy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    check_value("flush no done", 32'(seen), 32'd0);
    check_value("flush result hold", bus.result, last_exp);
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check_value("flush blocks start", 32'(bus.busy), 32'd0);
    run_op("after flush", 3'd6, 32'hFFFF_FF00, 32'd7, 1'b0);

    // Asynchronous reset in the middle of CALC.
    bus.op = 3'd3; bus.rs1 = $urandom; bus.rs2 = $urandom; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("async rst busy", 32'(bus.busy), 32'd0);
    check_value("async rst done", 32'(bus.done), 32'd0);
    check_value("async rst result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
